// File: rtl/ov5640_init_pkg.sv
// ov5640_init_pkg
//   Shared types and constants for the OV5640 init-table sequencer.
//   Optional feature macro: OV5640_INIT_READBACK_EN adds the READ/CHECK
//   states and the readback-eligibility helper.
package ov5640_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_LATCH,
        ST_WRITE,
        ST_DELAY,
        ST_NEXT,
`ifdef OV5640_INIT_READBACK_EN
        ST_READ,
        ST_CHECK,
`endif
        ST_DONE
    } state_t;

    localparam logic [15:0] SOFT_RST_ADDR = 16'h3008;
    localparam int          SOFT_RST_BIT  = 7;
    localparam logic [7:0]  SYS_REG_HI    = 8'h30;

    // A write to the system-control register with the reset bit set puts the
    // sensor into software reset; it needs a settle delay afterwards.
    function automatic logic is_soft_rst(input logic [15:0] addr, input logic [7:0] data);
        return (addr == SOFT_RST_ADDR) && data[SOFT_RST_BIT];
    endfunction

`ifdef OV5640_INIT_READBACK_EN
    // System registers (0x30xx, which includes 0x3008) self-clear or change
    // on write, so their readback value is meaningless.
    function automatic logic needs_readback(input logic [15:0] addr);
        return (addr != SOFT_RST_ADDR) && (addr[15:8] != SYS_REG_HI);
    endfunction
`endif

endpackage

// File: rtl/init_delay_timer.sv
// init_delay_timer
//   Loadable down-counter shared by the power-up wait, the soft-reset settle
//   delay and the SCCB ack timeout. Loading N makes 'expired' rise in the Nth
//   cycle after the load edge, so a state that leaves on 'expired' lasts
//   exactly N cycles.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   load          load load_val this cycle (takes priority over counting)
//   load_val      value to load
//   count         decrement enable
//   expired       terminal count reached
module init_delay_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             count,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Zero is included so a zero load cannot stall a waiting state.
    assign expired = (cnt <= CNT_W'(1));

endmodule

// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer
//   Walks the OV5640 init-table ROM and issues every entry as a 16-bit-address
//   SCCB register write over a req/ack port. Waits for sensor power-up before
//   the first write and inserts a settle delay after a software-reset write.
//   Optional feature macro: OV5640_INIT_READBACK_EN reads each eligible
//   register back after writing it and flags mismatches on err.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             1-cycle pulse, accepted in IDLE or DONE only
//   rom_addr, rom_q   ROM read port (1-cycle read latency)
//   wr_req/addr/data  SCCB write request, held until wr_ack
//   wr_ack            1-cycle transfer-complete pulse
//   rd_req/addr/data/rd_ack  readback port (OV5640_INIT_READBACK_EN only)
//   busy, done, err   status to the camera top level
module ov5640_init_sequencer
    import ov5640_init_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_WIDTH   = 8,
    parameter int TABLE_LEN    = 252,
    parameter int PWRUP_CYCLES = 1_000_000,
    parameter int RST_CYCLES   = 250_000,
    parameter int ACK_TIMEOUT  = 65_535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  wr_req,
    output logic [15:0]           wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  wr_ack,
`ifdef OV5640_INIT_READBACK_EN
    output logic                  rd_req,
    output logic [15:0]           rd_addr,
    input  logic [7:0]            rd_data,
    input  logic                  rd_ack,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_MAX = (PWRUP_CYCLES > RST_CYCLES)
        ? ((PWRUP_CYCLES > ACK_TIMEOUT) ? PWRUP_CYCLES : ACK_TIMEOUT)
        : ((RST_CYCLES   > ACK_TIMEOUT) ? RST_CYCLES   : ACK_TIMEOUT);
    localparam int TW = $clog2(CNT_MAX + 1);

    state_t          state;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_exp;
`ifdef OV5640_INIT_READBACK_EN
    logic [7:0]      rd_val;
`endif

    init_delay_timer #(.CNT_W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (busy),
        .expired  (tmr_exp)
    );

    // Timer loads on the same edge that enters a waiting state, so the first
    // cycle of that state already sees the full count.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PWRUP_CYCLES);
                end
            end
            ST_LATCH: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(ACK_TIMEOUT);
            end
            ST_WRITE: begin
`ifdef OV5640_INIT_READBACK_EN
                if (wr_ack && needs_readback(wr_addr)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ACK_TIMEOUT);
                end else if (wr_ack && is_soft_rst(wr_addr, wr_data)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RST_CYCLES);
                end
`else
                if (wr_ack && is_soft_rst(wr_addr, wr_data)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(RST_CYCLES);
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            wr_req   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef OV5640_INIT_READBACK_EN
            rd_req   <= 1'b0;
            rd_addr  <= '0;
            rd_val   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        state    <= ST_PWRUP;
                    end
                end
                ST_PWRUP: begin
                    if (tmr_exp) state <= ST_FETCH;
                end
                // rom_addr settled last cycle; this cycle covers ROM latency.
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    wr_addr <= rom_q[23:8];
                    wr_data <= rom_q[7:0];
                    wr_req  <= 1'b1;
                    state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
`ifdef OV5640_INIT_READBACK_EN
                        if (needs_readback(wr_addr)) begin
                            rd_req  <= 1'b1;
                            rd_addr <= wr_addr;
                            state   <= ST_READ;
                        end else if (is_soft_rst(wr_addr, wr_data)) begin
                            state <= ST_DELAY;
                        end else begin
                            state <= ST_NEXT;
                        end
`else
                        if (is_soft_rst(wr_addr, wr_data)) state <= ST_DELAY;
                        else                               state <= ST_NEXT;
`endif
                    end else if (tmr_exp) begin
                        wr_req <= 1'b0;
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DELAY: begin
                    if (tmr_exp) state <= ST_NEXT;
                end
`ifdef OV5640_INIT_READBACK_EN
                ST_READ: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        rd_val <= rd_data;
                        state  <= ST_CHECK;
                    end else if (tmr_exp) begin
                        rd_req <= 1'b0;
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                // A mismatch is sticky but does not abort the table.
                ST_CHECK: begin
                    if (rd_val != wr_data) err <= 1'b1;
                    state <= ST_NEXT;
                end
`endif
                ST_NEXT: begin
                    if (rom_addr == ADDR_WIDTH'(TABLE_LEN - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
module tb_ov5640_init_sequencer;

    localparam int TLEN = 4;
    localparam int PW   = 10;
    localparam int RC   = 20;
    localparam int AT   = 30;
`ifdef OV5640_INIT_READBACK_EN
    localparam int RBX  = 2;   // READ + CHECK cycles after a read-back write
`else
    localparam int RBX  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q = '0;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack = 1'b0;
    logic        busy, done, err;
`ifdef OV5640_INIT_READBACK_EN
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic        rd_ack = 1'b0;
    logic        flip_en = 1'b0;
`endif

    ov5640_init_sequencer #(
        .DATA_WIDTH(24), .ADDR_WIDTH(8), .TABLE_LEN(TLEN),
        .PWRUP_CYCLES(PW), .RST_CYCLES(RC), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
`ifdef OV5640_INIT_READBACK_EN
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
`endif
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [23:0] rom [256];
    always @(posedge clk) rom_q <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Write monitor / SCCB ack responder, all activity on the falling edge.
    logic [15:0] log_addr [16];
    logic [7:0]  log_data [16];
    int          log_rise [16];
    int          log_ack  [16];
    int          nw = 0;
    int          fall_cyc = 0;
    int          req_cnt = 0;
    logic        req_q = 1'b0;
    logic        ack_en = 1'b1;
    int          ack_dly = 5;

    initial begin
        forever begin
            @(negedge clk);
            wr_ack = 1'b0;
            if (wr_req && !req_q) begin
                if (nw < 16) begin
                    log_addr[nw] = wr_addr;
                    log_data[nw] = wr_data;
                    log_rise[nw] = cyc;
                end
                nw = nw + 1;
                req_cnt = 0;
            end
            if (!wr_req && req_q) fall_cyc = cyc;
            if (wr_req) begin
                req_cnt = req_cnt + 1;
                if (ack_en && req_cnt == ack_dly) begin
                    wr_ack = 1'b1;
                    if (nw >= 1 && nw <= 16) log_ack[nw-1] = cyc + 1;
                end
            end
            req_q = wr_req;
`ifdef OV5640_INIT_READBACK_EN
            rd_ack = 1'b0;
            if (rd_req) begin
                rd_ack  = 1'b1;
                rd_data = log_data[nw-1] ^ ((flip_en && rd_addr == 16'h3a13) ? 8'h01 : 8'h00);
            end
`endif
        end
    end

    typedef struct {
        int          run;
        logic [23:0] word;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        int          gmin;
        int          gmax;
    } vec_t;
    vec_t vt [8];

    int start_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL %s_timeout got done=0 want done=1 within 3000 clks", name);
        end
    endtask

    task automatic wait_req(input int target, input string name);
        int n;
        n = 0;
        while (!(wr_req && nw >= target) && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (!wr_req) begin
            errors = errors + 1;
            $display("FAIL %s_wait got wr_req=0 want wr_req=1 within 3000 clks", name);
        end
    endtask

    task automatic load_rom(input int r);
        int k;
        k = 0;
        for (int i = 0; i < 256; i++) rom[i] = 24'h0;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].run == r) begin
                rom[k] = vt[i].word;
                k = k + 1;
            end
        end
    endtask

    // Checks the logged writes of one completed run against the table.
    task automatic check_run(input int r);
        int k;
        int gap;
        int extra;
        k = 0;
        chk($sformatf("run%0d_nw", r), nw, TLEN);
        chk($sformatf("run%0d_done", r), done, 1);
        chk($sformatf("run%0d_busy", r), busy, 0);
        chk($sformatf("run%0d_err", r), err, 0);
        for (int i = 0; i < 8; i++) begin
            if (vt[i].run == r) begin
                chk($sformatf("run%0d_addr%0d", r, k), log_addr[k], vt[i].exp_addr);
                chk($sformatf("run%0d_data%0d", r, k), log_data[k], vt[i].exp_data);
                if (k == 0) begin
                    gap = log_rise[0] - start_cyc;
                    extra = 0;
                end else begin
                    gap = log_rise[k] - log_ack[k-1];
                    extra = (log_addr[k-1][15:8] != 8'h30) ? RBX : 0;
                end
                checks = checks + 1;
                if (gap < vt[i].gmin + extra || gap > vt[i].gmax + extra) begin
                    errors = errors + 1;
                    $display("FAIL run%0d_gap%0d got %0d want %0d..%0d", r, k, gap,
                             vt[i].gmin + extra, vt[i].gmax + extra);
                end
                k = k + 1;
            end
        end
    endtask

    initial begin
        vt[0] = '{0, 24'h310311, 16'h3103, 8'h11, PW + 2, PW + 2};
        vt[1] = '{0, 24'h3a1343, 16'h3a13, 8'h43, 3, 3};
        vt[2] = '{0, 24'h430030, 16'h4300, 8'h30, 3, 3};
        vt[3] = '{0, 24'h501f01, 16'h501f, 8'h01, 3, 3};
        vt[4] = '{1, 24'h310311, 16'h3103, 8'h11, PW + 2, PW + 2};
        vt[5] = '{1, 24'h300882, 16'h3008, 8'h82, 3, 3};
        vt[6] = '{1, 24'h300842, 16'h3008, 8'h42, RC, RC + 3};
        vt[7] = '{1, 24'h474021, 16'h4740, 8'h21, 3, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        reset_n = 1'b1;

        // Normal table, then table with soft-reset entries
        for (int r = 0; r < 2; r++) begin
            load_rom(r);
            nw = 0;
            pulse_start();
            chk($sformatf("run%0d_busy_start", r), busy, 1);
            wait_done($sformatf("run%0d", r));
            check_run(r);
        end

        // Ack never comes: timeout
        load_rom(0);
        ack_en = 1'b0;
        nw = 0;
        pulse_start();
        wait_done("tmo");
        chk("tmo_err", err, 1);
        chk("tmo_done", done, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_wr_req", wr_req, 0);
        chk("tmo_rom_addr", rom_addr, 0);
        chk("tmo_nw", nw, 1);
        chk("tmo_req_len", fall_cyc - log_rise[0], AT);

        // Restart from DONE clears status; start during WRITE is ignored
        ack_en = 1'b1;
        nw = 0;
        pulse_start();
        chk("rerun_done_clr", done, 0);
        chk("rerun_err_clr", err, 0);
        chk("rerun_busy", busy, 1);
        wait_req(2, "rerun");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("rerun");
        chk("rerun_nw", nw, TLEN);
        chk("rerun_first", log_addr[0], 16'h3103);
        chk("rerun_last", log_addr[3], 16'h501f);
        chk("rerun_err", err, 0);

        // Reset while a transfer is pending
        nw = 0;
        ack_dly = 8;
        pulse_start();
        wait_req(3, "mid_rst");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wr_req", wr_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_dly = 5;
        nw = 0;
        pulse_start();
        wait_done("after_rst");
        chk("after_rst_first", log_addr[0], 16'h3103);
        chk("after_rst_nw", nw, TLEN);

`ifdef OV5640_INIT_READBACK_EN
        // Readback mismatch on 0x3a13: flagged, but the table completes
        nw = 0;
        flip_en = 1'b1;
        pulse_start();
        wait_done("rb");
        chk("rb_err", err, 1);
        chk("rb_done", done, 1);
        chk("rb_nw", nw, TLEN);
        chk("rb_last", log_addr[3], 16'h501f);
        flip_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
